// File: rtl/int_responder.sv
// Z80 mode-2 interrupt responder: turns trap pulses into INT and drives the vector byte during acknowledge.
// Optional RETI (ED 4D) opcode snooping to end service when INT_RESPONDER_RETI_DETECT_EN is defined.
module int_responder #(
  parameter logic [7:0] VECTOR = 8'hF0
) (
  input  logic       clk,
  input  logic       reset_n,
  inout  wire  [7:0] data,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       trap_req,
  input  logic       ien,
  input  logic       svc_clear,
  output logic       int_n,
  output logic       in_service,
  output logic [2:0] missed
);

  localparam int unsigned MW = 3;
  localparam logic [MW-1:0] MISS_MAX = MW'(7);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK, S_SERV} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pend_flag;
  logic [MW-1:0] r_missed;
  logic          w_ack_cyc;
  logic          w_drive;
  logic          w_svc_end;
  logic          w_trap_busy;
  logic          w_miss;
  logic          w_unused;

  assign w_ack_cyc = !m1_n && !iorq_n;

`ifdef INT_RESPONDER_RETI_DETECT_EN
  logic [7:0] r_op;
  logic       r_op_vld;
  logic       r_m1_low;
  logic       r_ed_seen;
  logic       w_fetch;
  logic       w_eval;

  assign w_fetch = !m1_n && iorq_n && !rd_n;
  // A latched opcode is judged once, on the first clk M1 is seen high again.
  assign w_eval  = r_m1_low && m1_n && r_op_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= 8'h00;
      r_op_vld  <= 1'b0;
      r_m1_low  <= 1'b0;
      r_ed_seen <= 1'b0;
    end else begin
      r_m1_low <= !m1_n;
      if (w_fetch) begin
        r_op     <= data;
        r_op_vld <= 1'b1;
      end else if (w_eval) begin
        r_op_vld <= 1'b0;
      end
      if (w_eval) r_ed_seen <= (r_op == 8'hED);
    end
  end

  assign w_svc_end = w_eval && r_ed_seen && (r_op == 8'h4D);
  assign w_unused  = svc_clear;
`else
  assign w_svc_end = svc_clear;
  assign w_unused  = rd_n;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a trap coinciding with end of service counts as pending
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (trap_req)  w_state_nxt = S_PEND;
      S_PEND: if (w_ack_cyc) w_state_nxt = S_ACK;
      S_ACK:  if (m1_n)      w_state_nxt = S_SERV;
      S_SERV: if (w_svc_end) w_state_nxt = (r_pend_flag || trap_req) ? S_PEND : S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    int_n      = 1'b1;
    in_service = 1'b0;
    w_drive    = 1'b0;
    case (r_state)
      S_PEND: begin
        int_n   = !ien;
        w_drive = w_ack_cyc;
      end
      S_ACK:   w_drive    = w_ack_cyc;
      S_SERV:  in_service = 1'b1;
      default: ;
    endcase
  end

  assign data = (w_drive && reset_n) ? (VECTOR & 8'hFE) : 8'bz;

  assign w_trap_busy = trap_req && ((r_state == S_ACK) || (r_state == S_SERV));
  assign w_miss      = (trap_req && (r_state == S_PEND)) || (w_trap_busy && r_pend_flag);

  // One-deep trap queue plus saturating drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_flag <= 1'b0;
      r_missed    <= '0;
    end else begin
      if (w_miss && (r_missed != MISS_MAX)) r_missed <= r_missed + MW'(1);
      if ((r_state == S_SERV) && w_svc_end) r_pend_flag <= 1'b0;
      else if (w_trap_busy)                 r_pend_flag <= 1'b1;
    end
  end

  assign missed = r_missed;

endmodule

// File: doc/int_responder.md
# int_responder

Z80 mode-2 interrupt responder for the Nabu MegaMapper CPLD. It turns I/O-violation trap pulses into a Z80 `INT` request and supplies the vector byte during the interrupt-acknowledge cycle. It then tracks the in-service period until the handler returns. It sits beside the trap-capture registers on the shared Z80 data bus and drives that bus instead of sampling it.

## Interface
Parameters:
- `VECTOR`, 8'hF0: byte driven on `data` during interrupt acknowledge. Bit 0 is always driven 0.

Ports:
- `clk`  in  1: Z80 CPU clock. All state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `data`  inout  8: Z80 data bus. Driven only during acknowledge, otherwise 8'bZ.
- `m1_n`  in  1: Z80 M1, active low.
- `iorq_n`  in  1: Z80 IORQ, active low.
- `rd_n`  in  1: Z80 RD, active low.
- `trap_req`  in  1: one-`clk` pulse from violation logic.
- `ien`  in  1: interrupt enable from control register.
- `svc_clear`  in  1: one-`clk` pulse that ends service. Used only without the macro.
- `int_n`  out  1: Z80 INT, active low.
- `in_service`  out  1: high while the handler is running.
- `missed`  out  3: count of traps dropped while already pending, saturating.

## Operation
- States: IDLE, PEND, ACK, SERV. Reset state is IDLE.
- Reset values: `int_n`=1, `in_service`=0, `missed`=0, `pend_flag`=0, `ed_seen`=0, `data`=Z.
- IDLE:
  - `trap_req` → PEND.
- PEND:
  - `int_n` = !`ien`, combinational from state.
  - With `ien` low, the request is held pending but not asserted.
  - Sampled `m1_n`=0 and `iorq_n`=0 → ACK.
- ACK:
  - `int_n`=1.
  - Sampled `m1_n`=1 → SERV.
- SERV:
  - `in_service`=1.
  - The end-of-service event moves to PEND if `pend_flag` is set (clearing it), otherwise to IDLE.
- `data` = `VECTOR & 8'hFE` whenever state is PEND or ACK and `m1_n`=0 and `iorq_n`=0 (combinational). Otherwise Z.
  - Release is immediate on `m1_n` or `iorq_n` going high, or on `reset_n` low.
- `trap_req` in ACK or SERV:
  - Sets `pend_flag` if clear.
  - If `pend_flag` is already set, increments `missed` instead (saturates at 7).
- `trap_req` in PEND: increments `missed` (saturates at 7).
- `missed` clears only on reset.
- Opcode fetch is defined as `m1_n`=0, `iorq_n`=1, `rd_n`=0. The `data` value is latched every `clk` during a fetch. The latched byte is evaluated on the first `clk` where `m1_n` is sampled high after being low.

## Timing
- `trap_req` to `int_n` low: 1 `clk` (registered state, `ien` high).
- Vector valid on `data`: combinationally, from the Z80 asserting IORQ in the acknowledge cycle. It is held until IORQ/M1 rises. The Z80's added wait states give more than 1 `clk` of setup before sampling.
- `int_n` rises 1 `clk` after acknowledge is sampled. The Z80 ignores INT during acknowledge, so no double-take occurs.
- End-of-service to a new `int_n` low for a pending trap: 1 `clk`.
- Simultaneous `trap_req` and end-of-service in SERV: the trap sets `pend_flag` first, so the next state is PEND.
- Reset mid-acknowledge: `data` floats asynchronously and the state returns to IDLE. Any pending trap is lost.

## Configuration
- `INT_RESPONDER_RETI_DETECT_EN` defined:
  - An evaluated fetch of 8'hED sets `ed_seen`.
  - An evaluated fetch of 8'h4D with `ed_seen` set is the end-of-service event in SERV. It is ignored in other states.
  - Any other evaluated fetch clears `ed_seen`.
  - `svc_clear` is ignored.
- Undefined:
  - A `svc_clear` pulse in SERV is the end-of-service event.
  - No opcode snooping and no `ed_seen` register.

## Test plan
- Reset mid-operation: assert `reset_n` low with state=ACK while driving → `data`=Z within the same cycle, `int_n`=1, `missed`=0, state IDLE.
- Basic request: `trap_req` pulse with `ien`=1 → `int_n`=0 next clk. Acknowledge with `m1_n`=0, `iorq_n`=0 → `data`=8'hF0 (default VECTOR). `int_n`=1 next clk. `in_service`=1 after `m1_n` rises.
- Enable gating: `trap_req` with `ien`=0 → `int_n` stays 1 for 20 clks. Raise `ien` → `int_n`=0 next clk.
- Queuing: 3 `trap_req` pulses during SERV → `pend_flag` set, `missed`=2. End service → `int_n`=0 one clk later, state PEND.
- With macro: fetch sequence ED, 4D in SERV → IDLE, `in_service`=0. Fetch sequence ED, 00, 4D → stays SERV.
- Without macro: `svc_clear` pulse in SERV → IDLE. Fetch sequence ED, 4D → no effect.
